// File: rtl/trail_painter.sv
// Per-frame trail writer: on each synchronised frame tick, paints every moving
// player's head cell as a BLOCK x BLOCK square, reading each pixel first to flag crashes.
module trail_painter #(
    parameter int          NUM_PLAYERS = 2,
    parameter int          BLOCK       = 2,
    parameter int          FB_WIDTH    = 320,
    parameter int          X_OFFSET    = 8,
    parameter int          MAX_X       = 224,
    parameter int          MAX_Y       = 224,
    parameter logic [2:0]  PLAY_STATE  = 3'b010,
    parameter int          ADDR_W      = 20
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_clk,
    input  logic [2:0]               game_state,
    input  logic [8*NUM_PLAYERS-1:0] pos_x,
    input  logic [8*NUM_PLAYERS-1:0] pos_y,
    input  logic [15:0]              fb_rdata,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic [15:0]              fb_wdata,
    output logic                     fb_we,
    output logic                     fb_re,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_PLAYERS-1:0]   collision,
    output logic                     overrun
);
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [8:0] MAX_X9 = 9'(MAX_X);
    localparam logic [8:0] MAX_Y9 = 9'(MAX_Y);
    localparam logic [1:0] LAST   = 2'(BLOCK - 1);

    typedef enum logic [2:0] {IDLE, LATCH, RD, WR, DONE} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               fsync_q, fsync_d;
    logic [8*NUM_PLAYERS-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [8*NUM_PLAYERS-1:0] old_x_q, old_x_d, old_y_q, old_y_d;
    logic [NUM_PLAYERS-1:0]   old_v_q, old_v_d;
    logic [NUM_PLAYERS-1:0]   collision_q, collision_d;
    logic                     overrun_q, overrun_d;
    logic [PW-1:0]            p_q, p_d;
    logic [1:0]               row_q, row_d, col_q, col_d;

    logic                     run;
    logic                     tick;
    logic [7:0]               cur_x, cur_y;
    logic [ADDR_W-1:0]        pix_addr;

    logic [8*NUM_PLAYERS-1:0] scan_x, scan_y;
    int                       scan_start;
    logic                     scan_found;
    logic [PW-1:0]            scan_idx;
    logic [NUM_PLAYERS-1:0]   wall_hit;

    assign run   = (game_state == PLAY_STATE) && !Reset;
    // fsync_q[1] is the synchronised tick, fsync_q[2] its previous value.
    assign tick  = fsync_q[1] & ~fsync_q[2];
    assign cur_x = sx_q[8*p_q +: 8];
    assign cur_y = sy_q[8*p_q +: 8];

    assign pix_addr = (ADDR_W'(cur_x) + ADDR_W'(X_OFFSET)) * ADDR_W'(BLOCK)
                    + ADDR_W'(cur_y) * ADDR_W'(FB_WIDTH * BLOCK)
                    + ADDR_W'(row_q) * ADDR_W'(FB_WIDTH)
                    + ADDR_W'(col_q);

    assign collision = collision_q;
    assign overrun   = overrun_q;

    // Finds the next player to paint at or after scan_start in zero cycles,
    // flagging wall hits and passing over stationary players on the way.
    always_comb begin
        scan_x     = (state_q == LATCH) ? pos_x : sx_q;
        scan_y     = (state_q == LATCH) ? pos_y : sy_q;
        scan_start = (state_q == LATCH) ? 0 : int'(p_q) + 1;
        scan_found = 1'b0;
        scan_idx   = '0;
        wall_hit   = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (i >= scan_start && !scan_found) begin
                if ({1'b0, scan_x[8*i +: 8]} >= MAX_X9 || {1'b0, scan_y[8*i +: 8]} >= MAX_Y9) begin
                    wall_hit[i] = 1'b1;
                end else if (!(old_v_q[i] && scan_x[8*i +: 8] == old_x_q[8*i +: 8]
                               && scan_y[8*i +: 8] == old_y_q[8*i +: 8])) begin
                    scan_found = 1'b1;
                    scan_idx   = PW'(i);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fsync_d     = {fsync_q[1:0], frame_clk};
        sx_d        = sx_q;
        sy_d        = sy_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        old_v_d     = old_v_q;
        collision_d = collision_q;
        overrun_d   = overrun_q;
        p_d         = p_q;
        row_d       = row_q;
        col_d       = col_q;
        fb_addr     = '0;
        fb_wdata    = '0;
        fb_we       = 1'b0;
        fb_re       = 1'b0;
        done        = 1'b0;
        busy        = run && (state_q != IDLE);

        if (!run) begin
            state_d     = IDLE;
            old_v_d     = '0;
            collision_d = '0;
            overrun_d   = 1'b0;
            p_d         = '0;
            row_d       = '0;
            col_d       = '0;
        end else begin
            if (tick && state_q != IDLE) overrun_d = 1'b1;
            case (state_q)
                IDLE: if (tick) state_d = LATCH;
                LATCH: begin
                    sx_d        = pos_x;
                    sy_d        = pos_y;
                    p_d         = scan_idx;
                    row_d       = '0;
                    col_d       = '0;
                    collision_d = collision_q | wall_hit;
                    state_d     = scan_found ? RD : DONE;
                end
                RD: begin
                    fb_re   = 1'b1;
                    fb_addr = pix_addr;
                    state_d = WR;
                end
                WR: begin
                    fb_we    = 1'b1;
                    fb_addr  = pix_addr;
                    fb_wdata = 16'(p_q) + 16'd1;
                    if (fb_rdata != 16'd0) collision_d[p_q] = 1'b1;
                    if (row_q == LAST && col_q == LAST) begin
                        old_x_d[8*p_q +: 8] = cur_x;
                        old_y_d[8*p_q +: 8] = cur_y;
                        old_v_d[p_q]        = 1'b1;
                        collision_d         = collision_d | wall_hit;
                        p_d                 = scan_idx;
                        row_d               = '0;
                        col_d               = '0;
                        state_d             = scan_found ? RD : DONE;
                    end else begin
                        if (col_q == LAST) begin
                            col_d = '0;
                            row_d = row_q + 2'd1;
                        end else begin
                            col_d = col_q + 2'd1;
                        end
                        state_d = RD;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            fsync_q     <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            old_x_q     <= '0;
            old_y_q     <= '0;
            old_v_q     <= '0;
            collision_q <= '0;
            overrun_q   <= 1'b0;
            p_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            fsync_q     <= fsync_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            old_v_q     <= old_v_d;
            collision_q <= collision_d;
            overrun_q   <= overrun_d;
            p_q         <= p_d;
            row_q       <= row_d;
            col_q       <= col_d;
        end
    end
endmodule

// File: tb/tb_trail_painter.sv
// Directed bench for trail_painter: expected frame-buffer writes are queued from the
// address formula, and a small frame-buffer memory answers the read-before-write.
module tb_trail_painter;
    localparam int AW       = 20;
    localparam int BLOCK    = 2;
    localparam int FB_WIDTH = 320;
    localparam int X_OFFSET = 8;
    localparam logic [2:0] PLAY = 3'b010;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          frame_clk;
    logic [2:0]    game_state;
    logic [15:0]   pos_x, pos_y;
    logic [15:0]   fb_rdata;
    logic [AW-1:0] fb_addr;
    logic [15:0]   fb_wdata;
    logic          fb_we, fb_re, busy, done, overrun;
    logic [1:0]    collision;

    int                n_vec = 0;
    int                n_err = 0;
    logic [AW+15:0]    exp_q[$];
    logic [15:0]       fb_mem [int];
    bit                inject;

    always #10 Clk = ~Clk;

    trail_painter #(
        .NUM_PLAYERS(2), .BLOCK(BLOCK), .FB_WIDTH(FB_WIDTH), .X_OFFSET(X_OFFSET),
        .MAX_X(224), .MAX_Y(224), .PLAY_STATE(PLAY), .ADDR_W(AW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_state(game_state),
        .pos_x(pos_x), .pos_y(pos_y), .fb_rdata(fb_rdata), .fb_addr(fb_addr),
        .fb_wdata(fb_wdata), .fb_we(fb_we), .fb_re(fb_re), .busy(busy), .done(done),
        .collision(collision), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on writes, frame-buffer model on reads.
    task automatic monitor();
        logic [AW+15:0] e;
        if (fb_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(fb_addr), 32'(e[AW+15:16]));
                chk("wr_data", 32'(fb_wdata), 32'(e[15:0]));
            end
            fb_mem[int'(fb_addr)] = fb_wdata;
        end else if (fb_re === 1'b1) begin
            if (inject) fb_rdata = 16'h0002;
            else fb_rdata = fb_mem.exists(int'(fb_addr)) ? fb_mem[int'(fb_addr)] : 16'h0000;
            inject = 1'b0;
        end else begin
            fb_rdata = 16'h0000;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        monitor();
    endtask

    task automatic set_pos(input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1);
        pos_x = {x1, x0};
        pos_y = {y1, y0};
    endtask

    task automatic push_player(input int x, input int y, input int code);
        int a;
        for (int r = 0; r < BLOCK; r++) begin
            for (int c = 0; c < BLOCK; c++) begin
                a = (x + X_OFFSET) * BLOCK + y * FB_WIDTH * BLOCK + r * FB_WIDTH + c;
                exp_q.push_back({AW'(a), 16'(code)});
            end
        end
    endtask

    // Pulses frame_clk, follows the sweep from LATCH (cycle 1) to done.
    task automatic run_sweep(input string tag, input int exp_done, input logic [1:0] exp_coll,
                             input int repulse, input int abort_at);
        int cyc;
        bit seen_done;
        frame_clk = 1'b1;
        for (int k = 0; k < 10 && busy !== 1'b1; k++) step();
        frame_clk = 1'b0;
        if (busy !== 1'b1) begin
            chk({tag, "_start_timeout"}, 32'(busy), 32'd1);
            return;
        end
        cyc = 1;
        seen_done = 1'b0;
        while (!seen_done && cyc < 60) begin
            if (cyc == abort_at) begin
                game_state = 3'b000;
                step();
                chk({tag, "_abort_we"}, 32'(fb_we), 32'd0);
                chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
                chk({tag, "_abort_coll"}, 32'(collision), 32'd0);
                chk({tag, "_abort_overrun"}, 32'(overrun), 32'd0);
                exp_q.delete();
                return;
            end
            if (cyc == repulse) frame_clk = 1'b1;
            if (cyc == repulse + 3) frame_clk = 1'b0;
            step();
            cyc++;
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_collision"}, 32'(collision), 32'(exp_coll));
        exp_q.delete();
        step();
        chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen_busy;
        Reset      = 1'b1;
        frame_clk  = 1'b0;
        game_state = PLAY;
        pos_x      = '0;
        pos_y      = '0;
        fb_rdata   = '0;
        inject     = 1'b0;
        repeat (3) step();
        Reset = 1'b0;
        step();

        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_re", 32'(fb_re), 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_wdata", 32'(fb_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_coll", 32'(collision), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Both players paint on the first sweep.
        set_pos(8'd10, 8'd5, 8'd20, 8'd5);
        push_player(10, 5, 1);
        push_player(20, 5, 2);
        run_sweep("first", 18, 2'b00, -10, -1);
        chk("first_overrun", 32'(overrun), 32'd0);
        repeat (4) step();

        // Stationary P0 costs no cycles.
        set_pos(8'd10, 8'd5, 8'd21, 8'd5);
        push_player(21, 5, 2);
        run_sweep("p1_only", 10, 2'b00, -10, -1);
        repeat (4) step();

        // Non-zero read data on P0's first write flags P0.
        set_pos(8'd11, 8'd5, 8'd21, 8'd5);
        push_player(11, 5, 1);
        inject = 1'b1;
        run_sweep("hit_p0", 10, 2'b01, -10, -1);
        repeat (4) step();

        set_pos(8'd12, 8'd5, 8'd22, 8'd5);
        push_player(12, 5, 1);
        push_player(22, 5, 2);
        run_sweep("sticky", 18, 2'b01, -10, -1);
        repeat (4) step();

        // Wall: P1 at X=224 paints nothing.
        set_pos(8'd12, 8'd5, 8'd224, 8'd5);
        run_sweep("wall", 2, 2'b11, -10, -1);
        repeat (4) step();

        // A tick during the sweep is dropped and reported.
        set_pos(8'd13, 8'd5, 8'd30, 8'd30);
        push_player(13, 5, 1);
        push_player(30, 30, 2);
        run_sweep("overrun", 18, 2'b11, 5, -1);
        seen_busy = 1'b0;
        repeat (12) begin
            step();
            if (busy === 1'b1) seen_busy = 1'b1;
        end
        chk("no_second_sweep", 32'(seen_busy), 32'd0);
        chk("overrun_flag", 32'(overrun), 32'd1);

        // Leaving play mid-sweep aborts right after the first write.
        set_pos(8'd40, 8'd40, 8'd41, 8'd40);
        push_player(40, 40, 1);
        push_player(41, 40, 2);
        run_sweep("abort", 0, 2'b00, -10, 3);
        repeat (4) step();
        game_state = PLAY;
        repeat (4) step();

        // Same cell for both: all players repaint; only the higher index flags.
        set_pos(8'd100, 8'd100, 8'd100, 8'd100);
        push_player(100, 100, 1);
        push_player(100, 100, 2);
        run_sweep("same_cell", 18, 2'b10, -10, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
